// File: rtl/lit_cell_pkg.sv
// lit_cell_pkg
// Shared encodings for the SAT clause-bin literal cells.
//   - Variable/literal value encoding (2 bits): free, false, true, conflict.
//   - Saturating free-literal count encoding (2 bits): zero, one, many.
//   - cntInc: bumps a free-literal count by one, saturating at "many".
package lit_cell_pkg;

  localparam logic [1:0] VAL_FREE     = 2'b00;
  localparam logic [1:0] VAL_FALSE    = 2'b01;
  localparam logic [1:0] VAL_TRUE     = 2'b10;
  localparam logic [1:0] VAL_CONFLICT = 2'b11;

  localparam logic [1:0] CNT_ZERO = 2'b00;
  localparam logic [1:0] CNT_ONE  = 2'b01;
  localparam logic [1:0] CNT_MANY = 2'b11;

  // Any nonzero count (including the unused 10 code) becomes "many".
  // A zero count becomes "one".
  function automatic logic [1:0] cntInc(input logic [1:0] cnt);
    return {cnt[1] | cnt[0], 1'b1};
  endfunction

endpackage

// File: rtl/lit_cell.sv
// lit_cell
// One literal cell of a clause row. It holds the literal polarity and
// evaluates it against the current variable value. The cells of a row
// are chained together, and each cell adds to the row's free-literal
// count and to its satisfied, implication and conflict results.
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-low reset
//   wr_i             in   load polarity from var_value_i[2:1]
//   var_value_i      in   [2:1] variable value, [0] implied flag (unused here)
//   var_value_o      out  implication drive {value, implied}, zero when idle
//   freelitcnt_pre   in   free-literal count from previous cell
//   freelitcnt_next  out  free-literal count to next cell
//   imp_drv_i        in   clause is unit, free literal drives implication
//   conflict_c_o     out  literal sees a conflicting variable
//   conflict_c_drv_i in   enables conflict reporting
//   clausesat_o      out  literal is currently true
module lit_cell
  import lit_cell_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [2:0] var_value_i,
  output logic [2:0] var_value_o,
  input  logic [1:0] freelitcnt_pre,
  output logic [1:0] freelitcnt_next,
  input  logic       imp_drv_i,
  output logic       conflict_c_o,
  input  logic       conflict_c_drv_i,
  output logic       clausesat_o
);

  // The polarity is stored as the variable value that makes the literal
  // true. Code 00 means there is no literal, and code 11 is reserved.
  logic [1:0] r_lit;

  logic [1:0] w_varVal;
  logic       w_unusedImplied;
  logic       w_litValid;
  logic       w_litFree;
  logic       w_litTrue;

  assign w_varVal        = var_value_i[2:1];
  assign w_unusedImplied = var_value_i[0];

  // Polarity register. Reset takes priority over a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lit <= VAL_FREE;
    end else if (wr_i) begin
      r_lit <= w_varVal;
    end
  end

  // The reserved code 11 is treated the same as "no literal".
  assign w_litValid = (r_lit == VAL_FALSE) || (r_lit == VAL_TRUE);
  assign w_litFree  = w_litValid && (w_varVal == VAL_FREE);
  assign w_litTrue  = w_litValid && (w_varVal == r_lit);

  // The daisy-chained count passes straight through unless this literal
  // is free.
  always_comb begin
    freelitcnt_next = freelitcnt_pre;
    if (w_litFree) begin
      freelitcnt_next = cntInc(freelitcnt_pre);
    end
  end

  // The implication drive stays all zeros when idle, so that several cells
  // can be ORed onto one variable bus.
  always_comb begin
    var_value_o = 3'b000;
    if (imp_drv_i && w_litFree) begin
      var_value_o = {r_lit, 1'b1};
    end
  end

  assign clausesat_o  = w_litTrue;
  assign conflict_c_o = conflict_c_drv_i && w_litValid && (w_varVal == VAL_CONFLICT);

endmodule

// File: tb/tb_lit_cell.sv
// tb_lit_cell
// Scoreboard bench for lit_cell. The stimulus process drives the inputs
// and pushes the expected outputs, which come from a polarity/truth model.
// A monitor process samples on the falling edge, pops and compares.
module tb_lit_cell;

  logic       clk;
  logic       rst;
  logic       wr_i;
  logic [2:0] var_value_i;
  logic [2:0] var_value_o;
  logic [1:0] freelitcnt_pre;
  logic [1:0] freelitcnt_next;
  logic       imp_drv_i;
  logic       conflict_c_o;
  logic       conflict_c_drv_i;
  logic       clausesat_o;

  typedef struct packed {
    logic [2:0] varOut;
    logic [1:0] cntNext;
    logic       conflict;
    logic       sat;
  } expT;

  expT expQ[$];
  int  checksTotal  = 0;
  int  checksPassed = 0;

  // Model state: 0 means no literal, +1 a positive literal, -1 a negative one.
  int   modelPol = 0;
  logic prevRst  = 1'b0;
  logic prevWr   = 1'b0;
  logic [1:0] prevVal = 2'b00;

  lit_cell dut (
    .clk              (clk),
    .rst              (rst),
    .wr_i             (wr_i),
    .var_value_i      (var_value_i),
    .var_value_o      (var_value_o),
    .freelitcnt_pre   (freelitcnt_pre),
    .freelitcnt_next  (freelitcnt_next),
    .imp_drv_i        (imp_drv_i),
    .conflict_c_o     (conflict_c_o),
    .conflict_c_drv_i (conflict_c_drv_i),
    .clausesat_o      (clausesat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Maps a written value to a polarity. The reserved code and "free" both
  // mean that there is no literal.
  function automatic int polOf(input logic [1:0] v);
    if (v == 2'b10) return 1;
    if (v == 2'b01) return -1;
    return 0;
  endfunction

  // Computes the reference outputs from the literal's meaning: the literal
  // is true when the variable agrees with its polarity, and free when the
  // variable is unassigned. The count is a number that saturates at 2.
  function automatic expT model(input int pol, input logic [1:0] v,
                                input logic [1:0] pre, input logic imp,
                                input logic cdrv);
    expT e;
    bit  varTrue  = (v == 2'b10);
    bit  varFalse = (v == 2'b01);
    bit  varFree  = (v == 2'b00);
    bit  varConf  = (v == 2'b11);
    bit  litTrue  = (pol == 1 && varTrue) || (pol == -1 && varFalse);
    bit  litFree  = (pol != 0) && varFree;
    int  n;
    e.sat      = litTrue;
    e.conflict = cdrv && (pol != 0) && varConf;
    if (litFree) begin
      n = (pre == 2'b00) ? 1 : 2;
      e.cntNext = (n == 1) ? 2'b01 : 2'b11;
    end else begin
      e.cntNext = pre;
    end
    if (litFree && imp) e.varOut = {(pol == 1) ? 2'b10 : 2'b01, 1'b1};
    else                e.varOut = 3'b000;
    return e;
  endfunction

  // Issues one cycle of stimulus. The previous cycle's write or reset is
  // committed to the model at the edge, before the expected values are
  // pushed.
  task automatic applyStimulus(input logic rstN, input logic wr,
                               input logic [2:0] v, input logic [1:0] pre,
                               input logic imp, input logic cdrv);
    @(posedge clk);
    if (!prevRst)    modelPol = 0;
    else if (prevWr) modelPol = polOf(prevVal);
    #1;
    rst              = rstN;
    wr_i             = wr;
    var_value_i      = v;
    freelitcnt_pre   = pre;
    imp_drv_i        = imp;
    conflict_c_drv_i = cdrv;
    prevRst = rstN;
    prevWr  = wr;
    prevVal = v[2:1];
    expQ.push_back(model(modelPol, v[2:1], pre, imp, cdrv));
  endtask

  task automatic checkOutput(input string name, input logic [2:0] act,
                             input logic [2:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Monitor: the outputs are combinational, so every cycle with an
  // outstanding expectation is an observation point.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("var_value_o", var_value_o, e.varOut);
        checkOutput("freelitcnt_next", {1'b0, freelitcnt_next}, {1'b0, e.cntNext});
        checkOutput("conflict_c_o", {2'b00, conflict_c_o}, {2'b00, e.conflict});
        checkOutput("clausesat_o", {2'b00, clausesat_o}, {2'b00, e.sat});
      end
    end
  end

  initial begin
    int waitCycles;
    rst = 1'b0; wr_i = 1'b0; var_value_i = 3'b000; freelitcnt_pre = 2'b00;
    imp_drv_i = 1'b0; conflict_c_drv_i = 1'b0;

    // Reset state: with no literal, the count passes through and all else is zero.
    applyStimulus(1'b0, 1'b0, 3'b000, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b111, 2'b10, 1'b1, 1'b1);

    // Positive literal: free, false, true, saturation.
    applyStimulus(1'b1, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b110, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b110, 2'b00, 1'b0, 1'b0);

    // Negative literal and its implication drive. The old polarity holds
    // while the write strobe is high.
    applyStimulus(1'b1, 1'b1, 3'b010, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 2'b00, 1'b1, 1'b0);

    // An empty cell and the reserved code both behave as "no literal".
    applyStimulus(1'b1, 1'b1, 3'b000, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b110, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b110, 2'b01, 1'b1, 1'b1);

    // Reset wins over a simultaneous write.
    applyStimulus(1'b1, 1'b1, 3'b100, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b100, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 1'b1);

    // Randomized traffic, including mid-operation resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
                    3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checksTotal++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
